// File: rtl/param_bus_datapath_pkg.sv
// Shared definitions for the parameterised bus datapath: source-select offsets,
// fetch sequencer state encoding, sequencer strobe bundle and a clog2 helper.
package param_bus_datapath_pkg;

    // Bus source offsets above the general registers (src_sel = NREGS + offset)
    localparam int unsigned SRC_HI          = 0;
    localparam int unsigned SRC_LO          = 1;
    localparam int unsigned SRC_ZHI         = 2;
    localparam int unsigned SRC_ZLO         = 3;
    localparam int unsigned SRC_PC          = 4;
    localparam int unsigned SRC_MDR         = 5;
    localparam int unsigned SRC_INPORT      = 6;
    localparam int unsigned SRC_CSIGN       = 7;
    localparam int unsigned SRC_NUM_SPECIAL = 8;

    typedef enum logic [2:0] {
        FS_IDLE = 3'd0,
        FS_T0   = 3'd1,
        FS_T1   = 3'd2,
        FS_T2   = 3'd3,
        FS_DONE = 3'd4
    } fetchState_e;

    // Register load strobes the sequencer issues during a fetch
    typedef struct packed {
        logic marLd;
        logic pcInc;
        logic mdrLd;
        logic irLd;
    } fetchStrobe_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 0;
        while ((64'd1 << width) < 64'(value)) width = width + 1;
        return width;
    endfunction

endpackage

// File: rtl/param_bus_datapath_if.sv
// Control-unit / memory side signal bundle of the parameterised bus datapath.
interface param_bus_datapath_if
    import param_bus_datapath_pkg::*;
#(
    parameter int unsigned DW    = 32,
    parameter int unsigned NREGS = 16
);
    localparam int unsigned SELW = clog2(NREGS + SRC_NUM_SPECIAL);

    logic [SELW-1:0]  src_sel;
    logic [NREGS-1:0] r_in;
    logic             hi_in;
    logic             lo_in;
    logic             y_in;
    logic             pc_in;
    logic             ir_in;
    logic             mar_in;
    logic             mdr_in;
    logic             mdr_read;
    logic             z_in;
    logic [2*DW-1:0]  z_data;
    logic             inc_pc;
    logic [DW-1:0]    in_port;
    logic             fetch_start;
    logic             mem_ack;
    logic [DW-1:0]    mem_rdata;
    logic             mem_req;
    logic [DW-1:0]    mem_addr;
    logic [DW-1:0]    bus_out;
    logic [DW-1:0]    y_out;
    logic [DW-1:0]    ir_out;
    logic             fetch_busy;
    logic             fetch_done;
    logic             fetch_err;

    modport master (
        output src_sel, r_in, hi_in, lo_in, y_in, pc_in, ir_in, mar_in,
               mdr_in, mdr_read, z_in, z_data, inc_pc, in_port,
               fetch_start, mem_ack, mem_rdata,
        input  mem_req, mem_addr, bus_out, y_out, ir_out,
               fetch_busy, fetch_done, fetch_err
    );

    modport slave (
        input  src_sel, r_in, hi_in, lo_in, y_in, pc_in, ir_in, mar_in,
               mdr_in, mdr_read, z_in, z_data, inc_pc, in_port,
               fetch_start, mem_ack, mem_rdata,
        output mem_req, mem_addr, bus_out, y_out, ir_out,
               fetch_busy, fetch_done, fetch_err
    );

endinterface

// File: rtl/param_bus_datapath_fetch_seq.sv
// Instruction-fetch sequencer: IDLE -> T0 -> T1 (memory handshake, timeout) -> T2 -> DONE.
module param_bus_datapath_fetch_seq
    import param_bus_datapath_pkg::*;
#(
    parameter int unsigned MEM_TO = 15
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         fetchStart,
    input  logic         memAck,
    output logic         memReq,
    output logic         fetchBusy,
    output logic         fetchDone,
    output logic         fetchErr,
    output fetchStrobe_t strobe_c
);
    localparam int unsigned CNTW = clog2(MEM_TO + 1);

    fetchState_e     state;
    fetchState_e     nextState;
    logic [CNTW-1:0] waitCnt;
    logic            timeout;
    logic            startAccept;
    logic            memReqNext;
    logic            busyNext;
    logic            doneNext;
    logic            errNext;

    // Last unacknowledged T1 cycle before giving up
    assign timeout = (state == FS_T1) && !memAck && (waitCnt == CNTW'(MEM_TO - 1));

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) state <= FS_IDLE;
        else      state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            FS_IDLE: if (fetchStart) nextState = FS_T0;
            FS_T0:   nextState = FS_T1;
            FS_T1: begin
                if (memAck)       nextState = FS_T2;
                else if (timeout) nextState = FS_IDLE;
            end
            FS_T2:   nextState = FS_DONE;
            FS_DONE: nextState = FS_IDLE;
            default: nextState = FS_IDLE;
        endcase
    end

    // Strobes act on the edge that leaves the current state; flag outputs follow nextState
    always_comb begin
        strobe_c    = '0;
        startAccept = (state == FS_IDLE) && fetchStart;
        memReqNext  = (nextState == FS_T1);
        busyNext    = (nextState != FS_IDLE);
        doneNext    = (nextState == FS_DONE);
        errNext     = fetchErr;
        if (startAccept)  errNext = 1'b0;
        else if (timeout) errNext = 1'b1;
        case (state)
            FS_T0: begin
                strobe_c.marLd = 1'b1;
                strobe_c.pcInc = 1'b1;
            end
            FS_T1:   strobe_c.mdrLd = memAck;
            FS_T2:   strobe_c.irLd  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            memReq    <= 1'b0;
            fetchBusy <= 1'b0;
            fetchDone <= 1'b0;
            fetchErr  <= 1'b0;
            waitCnt   <= '0;
        end else begin
            memReq    <= memReqNext;
            fetchBusy <= busyNext;
            fetchDone <= doneNext;
            fetchErr  <= errNext;
            waitCnt   <= ((state == FS_T1) && (nextState == FS_T1)) ? waitCnt + CNTW'(1) : '0;
        end
    end

endmodule

// File: rtl/param_bus_datapath.sv
// Parameterised single-bus datapath: register file, special registers, bus mux
// and the instruction-fetch sequencer that owns MAR/PC/MDR/IR during a fetch.
module param_bus_datapath
    import param_bus_datapath_pkg::*;
#(
    parameter int unsigned   DW      = 32,
    parameter int unsigned   NREGS   = 16,
    parameter bit            ZERO_R0 = 1'b0,
    parameter int unsigned   CW      = 19,
    parameter int unsigned   MEM_TO  = 15,
    parameter logic [DW-1:0] PC_RST  = '0
) (
    input logic                 clk,
    input logic                 clr,
    param_bus_datapath_if.slave bif
);
    localparam int unsigned SELW = clog2(NREGS + SRC_NUM_SPECIAL);

    logic [DW-1:0] regQ [NREGS];
    logic [DW-1:0] hiQ, loQ, zHiQ, zLoQ, yQ, pcQ, irQ, marQ, mdrQ;
    logic [DW-1:0] busC;
    logic [DW-1:0] cSign;
    fetchStrobe_t  strobe;
    logic          memReq, fetchBusy, fetchDone, fetchErr;
    logic          extEn;

    param_bus_datapath_fetch_seq #(.MEM_TO(MEM_TO)) uFetchSeq (
        .clk        (clk),
        .clr        (clr),
        .fetchStart (bif.fetch_start),
        .memAck     (bif.mem_ack),
        .memReq     (memReq),
        .fetchBusy  (fetchBusy),
        .fetchDone  (fetchDone),
        .fetchErr   (fetchErr),
        .strobe_c   (strobe)
    );

    // The control unit loses every load enable while the sequencer owns the datapath
    assign extEn = !fetchBusy;
    assign cSign = DW'($signed(irQ[CW-1:0]));

    always_comb begin
        busC = '0;
        for (int i = 0; i < int'(NREGS); i++) begin
            if (bif.src_sel == SELW'(i)) busC = regQ[i];
        end
        case (bif.src_sel)
            SELW'(NREGS + SRC_HI):     busC = hiQ;
            SELW'(NREGS + SRC_LO):     busC = loQ;
            SELW'(NREGS + SRC_ZHI):    busC = zHiQ;
            SELW'(NREGS + SRC_ZLO):    busC = zLoQ;
            SELW'(NREGS + SRC_PC):     busC = pcQ;
            SELW'(NREGS + SRC_MDR):    busC = mdrQ;
            SELW'(NREGS + SRC_INPORT): busC = bif.in_port;
            SELW'(NREGS + SRC_CSIGN):  busC = cSign;
            default: ;
        endcase
    end

    for (genvar i = 0; i < int'(NREGS); i++) begin : gReg
        localparam bit HARD_ZERO = ZERO_R0 && (i == 0);
        logic we;
        assign we = extEn && bif.r_in[i] && !HARD_ZERO;
        always_ff @(posedge clk or negedge clr) begin
            if (!clr)    regQ[i] <= '0;
            else if (we) regQ[i] <= busC;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            hiQ  <= '0;
            loQ  <= '0;
            zHiQ <= '0;
            zLoQ <= '0;
            yQ   <= '0;
        end else begin
            if (extEn && bif.hi_in) hiQ <= busC;
            if (extEn && bif.lo_in) loQ <= busC;
            if (extEn && bif.y_in)  yQ  <= busC;
            if (extEn && bif.z_in) begin
                zHiQ <= bif.z_data[2*DW-1:DW];
                zLoQ <= bif.z_data[DW-1:0];
            end
        end
    end

    // Sequencer strobes and gated external enables never overlap, so plain priority suffices
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            pcQ  <= PC_RST;
            marQ <= '0;
            mdrQ <= '0;
            irQ  <= '0;
        end else begin
            if (extEn && bif.pc_in)                        pcQ <= busC;
            else if (strobe.pcInc || (extEn && bif.inc_pc)) pcQ <= pcQ + DW'(1);

            if (strobe.marLd)                marQ <= pcQ;
            else if (extEn && bif.mar_in)    marQ <= busC;

            if (strobe.mdrLd)                mdrQ <= bif.mem_rdata;
            else if (extEn && bif.mdr_in)    mdrQ <= bif.mdr_read ? bif.mem_rdata : busC;

            if (strobe.irLd)                 irQ <= mdrQ;
            else if (extEn && bif.ir_in)     irQ <= busC;
        end
    end

    assign bif.bus_out    = busC;
    assign bif.mem_addr   = marQ;
    assign bif.y_out      = yQ;
    assign bif.ir_out     = irQ;
    assign bif.mem_req    = memReq;
    assign bif.fetch_busy = fetchBusy;
    assign bif.fetch_done = fetchDone;
    assign bif.fetch_err  = fetchErr;

endmodule

// File: tb/tb_param_bus_datapath.sv
// Scoreboard bench for param_bus_datapath (DW=32, NREGS=16, ZERO_R0=1, CW=19, MEM_TO=15).
module tb_param_bus_datapath;
    localparam int unsigned DW    = 32;
    localparam int unsigned NREGS = 16;
    localparam int unsigned SELW  = 5;
    localparam logic [31:0] PC_RST = 32'h0000_0100;
    localparam logic [SELW-1:0] S_HI = 5'd16, S_LO = 5'd17, S_ZHI = 5'd18, S_ZLO = 5'd19,
                                S_PC = 5'd20, S_MDR = 5'd21, S_INP = 5'd22, S_CSIGN = 5'd23;

    logic clk = 1'b0;
    logic clr = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] expIr[$];
    logic [31:0] expAddr[$];
    logic [31:0] monExp;
    logic        reqPrev = 1'b0;

    always #5 clk = ~clk;

    param_bus_datapath_if #(.DW(DW), .NREGS(NREGS)) bif ();

    param_bus_datapath #(
        .DW(DW), .NREGS(NREGS), .ZERO_R0(1'b1), .CW(19), .MEM_TO(15), .PC_RST(PC_RST)
    ) dut (
        .clk (clk),
        .clr (clr),
        .bif (bif)
    );

    // Scoreboard: fetch address on each mem_req rise, fetched word on each fetch_done
    always @(negedge clk) begin
        if (bif.mem_req && !reqPrev) begin
            checks++;
            if (expAddr.size() == 0) begin
                errors++;
                $display("FAIL mem_req_unexpected: mem_addr=%h with no fetch outstanding", bif.mem_addr);
            end else begin
                monExp = expAddr.pop_front();
                if (bif.mem_addr !== monExp) begin
                    errors++;
                    $display("FAIL fetch_addr: got %h expected %h", bif.mem_addr, monExp);
                end
            end
        end
        reqPrev = bif.mem_req;
        if (bif.fetch_done) begin
            checks++;
            if (expIr.size() == 0) begin
                errors++;
                $display("FAIL fetch_done_unexpected: ir_out=%h with no fetch outstanding", bif.ir_out);
            end else begin
                monExp = expIr.pop_front();
                if (bif.ir_out !== monExp) begin
                    errors++;
                    $display("FAIL fetch_ir: got %h expected %h", bif.ir_out, monExp);
                end
            end
        end
    end

    task automatic idle_inputs();
        bif.src_sel = '0;  bif.r_in = '0;    bif.hi_in = 1'b0;  bif.lo_in = 1'b0;
        bif.y_in = 1'b0;   bif.pc_in = 1'b0; bif.ir_in = 1'b0;  bif.mar_in = 1'b0;
        bif.mdr_in = 1'b0; bif.mdr_read = 1'b0; bif.z_in = 1'b0; bif.z_data = '0;
        bif.inc_pc = 1'b0; bif.in_port = '0; bif.fetch_start = 1'b0;
        bif.mem_ack = 1'b0; bif.mem_rdata = '0;
    endtask

    task automatic read_sel(input logic [SELW-1:0] sel, output logic [31:0] val);
        bif.src_sel = sel;
        #1;
        val = bif.bus_out;
    endtask

    // Drives one fetch from a negedge and reports what the DUT did over 30 cycles
    task automatic do_fetch(input logic [31:0] data, input int ackDelay, input bit poke,
                            output int t1Cycles, output int doneCycles, output int doneAt,
                            output logic errAtT0);
        t1Cycles = 0; doneCycles = 0; doneAt = -1; errAtT0 = 1'b0;
        bif.fetch_start = 1'b1;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            idle_inputs();
            if (n == 1) begin
                errAtT0 = bif.fetch_err;
                bif.mem_ack = 1'b1;
                bif.mem_rdata = 32'hBAD0_BAD0;
            end
            if (poke && (n == 1 || n == 2)) begin
                bif.in_port = 32'h0000_0099; bif.src_sel = S_INP; bif.r_in[2] = 1'b1;
                bif.hi_in = 1'b1; bif.inc_pc = 1'b1; bif.fetch_start = 1'b1;
            end
            if (bif.mem_req) begin
                t1Cycles++;
                if (ackDelay >= 0 && t1Cycles == ackDelay + 1) begin
                    bif.mem_ack = 1'b1;
                    bif.mem_rdata = data;
                    expIr.push_back(data);
                end
            end
            if (bif.fetch_done) begin
                doneCycles++;
                if (doneAt < 0) doneAt = n;
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] v;
        idle_inputs();
        #2 clr = 1'b0;
        repeat (3) @(negedge clk);
        clr = 1'b1;
        read_sel(S_PC, v);
        checks++; if (v !== PC_RST) begin errors++; $display("FAIL reset_pc: got %h expected %h", v, PC_RST); end
        checks++; if (bif.ir_out !== 32'h0) begin errors++; $display("FAIL reset_ir: got %h expected 0", bif.ir_out); end
        checks++; if ({bif.mem_req, bif.fetch_busy, bif.fetch_done, bif.fetch_err} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags: got %b expected 0000",
                               {bif.mem_req, bif.fetch_busy, bif.fetch_done, bif.fetch_err}); end
        checks++; if ({bif.y_out, bif.mem_addr} !== 64'h0) begin
            errors++; $display("FAIL reset_y_mar: got %h/%h expected 0/0", bif.y_out, bif.mem_addr); end
    endtask

    task automatic test_reset_mid_fetch();
        logic [31:0] v;
        int dones;
        bit inT1;
        bif.in_port = 32'hCAFE_F00D; bif.src_sel = S_INP; bif.ir_in = 1'b1;
        @(negedge clk); idle_inputs();
        checks++; if (bif.ir_out !== 32'hCAFE_F00D) begin errors++; $display("FAIL ir_load: got %h expected cafef00d", bif.ir_out); end
        expAddr.push_back(PC_RST);
        bif.fetch_start = 1'b1;
        inT1 = 1'b0;
        for (int n = 0; n < 10 && !inT1; n++) begin
            @(negedge clk); idle_inputs();
            inT1 = bif.mem_req;
        end
        checks++; if (!inT1) begin errors++; $display("FAIL midfetch_reach_t1: mem_req got 0 expected 1 within 10 cycles"); end
        #2 clr = 1'b0;
        @(negedge clk);
        read_sel(S_PC, v);
        checks++; if (v !== PC_RST) begin errors++; $display("FAIL midfetch_pc: got %h expected %h", v, PC_RST); end
        checks++; if (bif.ir_out !== 32'h0) begin errors++; $display("FAIL midfetch_ir: got %h expected 0", bif.ir_out); end
        checks++; if ({bif.mem_req, bif.fetch_busy, bif.fetch_done} !== 3'b000) begin
            errors++; $display("FAIL midfetch_flags: got %b expected 000", {bif.mem_req, bif.fetch_busy, bif.fetch_done}); end
        clr = 1'b1;
        dones = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (bif.fetch_done) dones++;
        end
        idle_inputs();
        checks++; if (dones !== 0) begin errors++; $display("FAIL midfetch_no_done: got %0d done cycles expected 0", dones); end
    endtask

    task automatic test_bus_write();
        logic [31:0] v;
        bif.in_port = 32'hDEAD_BEEF; bif.src_sel = S_INP; bif.r_in = 16'h0088;
        @(negedge clk); idle_inputs();
        read_sel(5'd3, v);
        checks++; if (v !== 32'hDEAD_BEEF) begin errors++; $display("FAIL r3_read: got %h expected deadbeef", v); end
        read_sel(5'd7, v);
        checks++; if (v !== 32'hDEAD_BEEF) begin errors++; $display("FAIL r7_read: got %h expected deadbeef", v); end
        read_sel(5'd5, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL r5_untouched: got %h expected 0", v); end
        @(negedge clk);
        bif.in_port = 32'h0BAD_CAFE; bif.src_sel = S_INP; bif.hi_in = 1'b1; bif.y_in = 1'b1;
        bif.mar_in = 1'b1; bif.mdr_in = 1'b1; bif.z_in = 1'b1; bif.z_data = 64'h1111_2222_3333_4444;
        @(negedge clk); idle_inputs();
        read_sel(S_HI, v);
        checks++; if (v !== 32'h0BAD_CAFE) begin errors++; $display("FAIL hi_multi: got %h expected 0badcafe", v); end
        checks++; if ({bif.y_out, bif.mem_addr} !== {32'h0BAD_CAFE, 32'h0BAD_CAFE}) begin
            errors++; $display("FAIL y_mar_multi: got %h/%h expected 0badcafe/0badcafe", bif.y_out, bif.mem_addr); end
        read_sel(S_MDR, v);
        checks++; if (v !== 32'h0BAD_CAFE) begin errors++; $display("FAIL mdr_from_bus: got %h expected 0badcafe", v); end
        read_sel(S_ZHI, v);
        checks++; if (v !== 32'h1111_2222) begin errors++; $display("FAIL zhi: got %h expected 11112222", v); end
        read_sel(S_ZLO, v);
        checks++; if (v !== 32'h3333_4444) begin errors++; $display("FAIL zlo: got %h expected 33334444", v); end
        read_sel(S_LO, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL lo_untouched: got %h expected 0", v); end
        @(negedge clk);
        bif.src_sel = 5'd3; bif.lo_in = 1'b1;
        bif.mdr_in = 1'b1; bif.mdr_read = 1'b1; bif.mem_rdata = 32'h600D_D00D;
        @(negedge clk); idle_inputs();
        read_sel(S_LO, v);
        checks++; if (v !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lo_from_r3: got %h expected deadbeef", v); end
        read_sel(S_MDR, v);
        checks++; if (v !== 32'h600D_D00D) begin errors++; $display("FAIL mdr_from_mem: got %h expected 600dd00d", v); end
        bif.in_port = 32'hFFFF_FFFF;
        read_sel(5'd31, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL sel_out_of_range: got %h expected 0", v); end
        @(negedge clk); idle_inputs();
    endtask

    task automatic test_fetch();
        logic [31:0] v;
        int t1, dc, da;
        logic e0;
        bif.in_port = 32'h0000_0010; bif.src_sel = S_INP; bif.pc_in = 1'b1;
        @(negedge clk); idle_inputs();
        expAddr.push_back(32'h0000_0010);
        do_fetch(32'h1234_5678, 2, 1'b0, t1, dc, da, e0);
        checks++; if (t1 !== 3) begin errors++; $display("FAIL fetch_t1_cycles: got %0d expected 3", t1); end
        checks++; if (dc !== 1) begin errors++; $display("FAIL fetch_done_width: got %0d expected 1", dc); end
        checks++; if (da !== 6) begin errors++; $display("FAIL fetch_done_cycle: got %0d expected 6", da); end
        checks++; if (bif.ir_out !== 32'h1234_5678) begin errors++; $display("FAIL fetch_ir_hold: got %h expected 12345678", bif.ir_out); end
        checks++; if (bif.mem_addr !== 32'h0000_0010) begin errors++; $display("FAIL fetch_mar: got %h expected 10", bif.mem_addr); end
        read_sel(S_PC, v);
        checks++; if (v !== 32'h0000_0011) begin errors++; $display("FAIL fetch_pc: got %h expected 11", v); end
    endtask

    task automatic test_timeout();
        logic [31:0] v;
        int t1, dc, da;
        logic e0;
        expAddr.push_back(32'h0000_0011);
        do_fetch(32'h0, -1, 1'b0, t1, dc, da, e0);
        checks++; if (t1 !== 15) begin errors++; $display("FAIL timeout_t1_cycles: got %0d expected 15", t1); end
        checks++; if ({bif.fetch_err, bif.fetch_busy, bif.mem_req} !== 3'b100) begin
            errors++; $display("FAIL timeout_flags: got %b expected 100", {bif.fetch_err, bif.fetch_busy, bif.mem_req}); end
        checks++; if (dc !== 0) begin errors++; $display("FAIL timeout_no_done: got %0d expected 0", dc); end
        checks++; if (bif.ir_out !== 32'h1234_5678) begin errors++; $display("FAIL timeout_ir: got %h expected 12345678", bif.ir_out); end
        read_sel(S_PC, v);
        checks++; if (v !== 32'h0000_0012) begin errors++; $display("FAIL timeout_pc: got %h expected 12", v); end
        repeat (3) @(negedge clk);
        idle_inputs();
        checks++; if (bif.fetch_err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", bif.fetch_err); end
        expAddr.push_back(32'h0000_0012);
        do_fetch(32'h0004_0000, 0, 1'b0, t1, dc, da, e0);
        checks++; if (e0 !== 1'b0) begin errors++; $display("FAIL err_cleared: got %b expected 0", e0); end
        checks++; if (da !== 4) begin errors++; $display("FAIL min_fetch_cycle: got %0d expected 4", da); end
        checks++; if (dc !== 1) begin errors++; $display("FAIL min_fetch_width: got %0d expected 1", dc); end
    endtask

    task automatic test_zero_r0_csign();
        logic [31:0] v;
        read_sel(S_CSIGN, v);
        checks++; if (v !== 32'hFFFC_0000) begin errors++; $display("FAIL csign_neg: got %h expected fffc0000", v); end
        bif.in_port = 32'h0000_0005; bif.src_sel = S_INP; bif.r_in = 16'h0003;
        @(negedge clk); idle_inputs();
        read_sel(5'd0, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL r0_hardwired: got %h expected 0", v); end
        read_sel(5'd1, v);
        checks++; if (v !== 32'h0000_0005) begin errors++; $display("FAIL r1_write: got %h expected 5", v); end
        @(negedge clk); idle_inputs();
    endtask

    task automatic test_pc_priority_busy();
        logic [31:0] v;
        int t1, dc, da;
        logic e0;
        bif.in_port = 32'h0000_0040; bif.src_sel = S_INP; bif.pc_in = 1'b1; bif.inc_pc = 1'b1;
        @(negedge clk); idle_inputs();
        read_sel(S_PC, v);
        checks++; if (v !== 32'h0000_0040) begin errors++; $display("FAIL pc_priority: got %h expected 40", v); end
        bif.in_port = 32'hFFFF_FFFF; bif.src_sel = S_INP; bif.pc_in = 1'b1;
        @(negedge clk); idle_inputs();
        bif.inc_pc = 1'b1;
        @(negedge clk); idle_inputs();
        read_sel(S_PC, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL pc_wrap: got %h expected 0", v); end
        bif.in_port = 32'h0000_0022; bif.src_sel = S_INP; bif.r_in[2] = 1'b1;
        @(negedge clk); idle_inputs();
        expAddr.push_back(32'h0);
        do_fetch(32'h55AA_55AA, 1, 1'b1, t1, dc, da, e0);
        read_sel(5'd2, v);
        checks++; if (v !== 32'h0000_0022) begin errors++; $display("FAIL busy_r2: got %h expected 22", v); end
        read_sel(S_HI, v);
        checks++; if (v !== 32'h0BAD_CAFE) begin errors++; $display("FAIL busy_hi: got %h expected 0badcafe", v); end
        read_sel(S_PC, v);
        checks++; if (v !== 32'h0000_0001) begin errors++; $display("FAIL busy_pc: got %h expected 1", v); end
        checks++; if (dc !== 1) begin errors++; $display("FAIL busy_single_fetch: got %0d done cycles expected 1", dc); end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_reset_mid_fetch();
        test_bus_write();
        test_fetch();
        test_timeout();
        test_zero_r0_csign();
        test_pc_priority_busy();
        checks++;
        if (expIr.size() != 0 || expAddr.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d ir / %0d addr entries left expected 0/0",
                     expIr.size(), expAddr.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
